// File: rtl/tube_ula_pkg.sv
// Shared constants for the Tube ULA: register indices, flag bit positions
// inside the control register and the layout of the status byte.
package tube_pkg;

  localparam logic [2:0] ADDR_CTRL = 3'd0;

  localparam int R1 = 0;
  localparam int R2 = 1;
  localparam int R3 = 2;
  localparam int R4 = 3;

  localparam int FLAG_T = 6;
  localparam int FLAG_P = 5;
  localparam int FLAG_V = 4;
  localparam int FLAG_M = 3;
  localparam int FLAG_J = 2;
  localparam int FLAG_I = 1;
  localparam int FLAG_Q = 0;

  localparam int ST_NE = 7;
  localparam int ST_NF = 6;

  // Status byte: data-available and space-available bits over the low field.
  function automatic logic [7:0] status_byte(input logic not_empty,
                                             input logic not_full,
                                             input logic [5:0] low);
    logic [7:0] b;
    b = {2'b00, low};
    b[ST_NE] = not_empty;
    b[ST_NF] = not_full;
    return b;
  endfunction

endpackage

// File: rtl/tube_ula_if.sv
// Host and parasite control/handshake signals. The two data buses are
// bidirectional and stay as plain inout ports on the ULA itself.
interface tube_ula_if;
  logic       h_cs_b;
  logic       h_rdnw;
  logic [2:0] h_addr;
  logic       h_irq_b;
  logic       p_cs_b;
  logic       p_rd_b;
  logic       p_wr_b;
  logic [2:0] p_addr;
  logic       p_irq_b;
  logic       p_nmi_b;
  logic       p_rst_b;

  modport master (
    output h_cs_b, h_rdnw, h_addr, p_cs_b, p_rd_b, p_wr_b, p_addr,
    input  h_irq_b, p_irq_b, p_nmi_b, p_rst_b
  );

  modport slave (
    input  h_cs_b, h_rdnw, h_addr, p_cs_b, p_rd_b, p_wr_b, p_addr,
    output h_irq_b, p_irq_b, p_nmi_b, p_rst_b
  );
endinterface

// File: rtl/tube_ula_fifo.sv
// Small shift FIFO. Entry 0 is always the head; when the FIFO drains, entry 0
// keeps the last byte popped so an empty read returns it. Fullness is judged
// against a runtime threshold so R3 can run at one or two entries.
module tube_fifo #(
  parameter int unsigned DEPTH         = 1,
  parameter bit          JUNK_ON_FLUSH = 1'b0,
  localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  input  logic [CW-1:0] full_thresh,
  output logic [7:0]    dout,
  output logic          not_empty,
  output logic          full
);

  logic [7:0]    mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign not_empty = (cnt_q != '0);
  assign full      = (cnt_q >= full_thresh);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & not_empty;
  assign dout      = mem_q[0];

  // Push and pop both judged on the pre-edge count; flush reloads junk if asked.
  always_ff @(negedge clk) begin
    if (!rst_b || flush) begin
      cnt_q    <= JUNK_ON_FLUSH ? CW'(1) : '0;
      mem_q[0] <= 8'h00;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (pop_ok) begin
          if (push_ok && CW'(i + 1) == cnt_q)
            mem_q[i] <= din;
          else if ((i + 1 < int'(DEPTH)) && (CW'(i + 1) < cnt_q))
            mem_q[i] <= mem_q[(i + 1 < int'(DEPTH)) ? i + 1 : i];
        end else if (push_ok && CW'(i) == cnt_q) begin
          mem_q[i] <= din;
        end
      end
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/tube_ula.sv
// Tube ULA: host 6502-side bus and asynchronous-strobe parasite bus joined by
// four register pairs, with control flags and interrupt/reset generation.
// Everything advances on the falling edge of h_phi2.
module tube_ula
  import tube_pkg::*;
#(
  parameter int unsigned R3_DEPTH = 2
) (
  input  logic       h_phi2,
  input  logic       h_rst_b,
  tube_ula_if.slave  bus,
  inout  wire  [7:0] h_data,
  inout  wire  [7:0] p_data
);

  logic [6:0] flags_q, flags_d;
  logic [3:0] h2p_ne, h2p_full, h2p_push, h2p_pop;
  logic [3:0] p2h_ne, p2h_full, p2h_push, p2h_pop;
  logic [7:0] h2p_dout [4];
  logic [7:0] p2h_dout [4];
  logic [2:0] p_cs_sync_q, p_rd_sync_q, p_wr_sync_q;
  logic [2:0] p_addr_q;
  logic [7:0] p_wdata_q;
  logic       h_wr, h_rd, p_wr_rise, p_rd_rise;
  logic [1:0] h_n, p_n;
  logic [7:0] h_rdata, p_rdata;

  assign h_wr = ~bus.h_cs_b & ~bus.h_rdnw;
  assign h_rd = ~bus.h_cs_b &  bus.h_rdnw;
  assign h_n  = bus.h_addr[2:1];
  assign p_n  = bus.p_addr[2:1];

  // Bit7 of a control write is the value given to every flag selected in bits 6..0.
  always_comb begin
    flags_d = flags_q;
    if (h_wr && bus.h_addr == ADDR_CTRL)
      flags_d = (flags_q & ~h_data[6:0]) | ({7{h_data[7]}} & h_data[6:0]);
  end

  // Control flags register.
  always_ff @(negedge h_phi2) begin
    if (!h_rst_b) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  // Two-flop synchronisers plus one history flop for edge detection on the strobes.
  always_ff @(negedge h_phi2) begin
    if (!h_rst_b) begin
      p_cs_sync_q <= 3'b111;
      p_rd_sync_q <= 3'b111;
      p_wr_sync_q <= 3'b111;
    end else begin
      p_cs_sync_q <= {p_cs_sync_q[1:0], bus.p_cs_b};
      p_rd_sync_q <= {p_rd_sync_q[1:0], bus.p_rd_b};
      p_wr_sync_q <= {p_wr_sync_q[1:0], bus.p_wr_b};
    end
  end

  // Capture address (and write data) from the raw bus while a strobe is held.
  always_ff @(negedge h_phi2) begin
    if (!h_rst_b) begin
      p_addr_q  <= '0;
      p_wdata_q <= '0;
    end else if (!bus.p_cs_b && !(bus.p_rd_b && bus.p_wr_b)) begin
      p_addr_q <= bus.p_addr;
      if (!bus.p_wr_b) p_wdata_q <= p_data;
    end
  end

  // The access completes when the synchronised strobe releases while selected.
  assign p_wr_rise = p_wr_sync_q[1] & ~p_wr_sync_q[2] & ~p_cs_sync_q[2];
  assign p_rd_rise = p_rd_sync_q[1] & ~p_rd_sync_q[2] & ~p_cs_sync_q[2];

  // Route push/pop strobes to the addressed register pair.
  always_comb begin
    h2p_push = '0;
    p2h_pop  = '0;
    p2h_push = '0;
    h2p_pop  = '0;
    if (h_wr && bus.h_addr[0])       h2p_push[h_n]           = 1'b1;
    if (h_rd && bus.h_addr[0])       p2h_pop[h_n]            = 1'b1;
    if (p_wr_rise && p_addr_q[0])    p2h_push[p_addr_q[2:1]] = 1'b1;
    if (p_rd_rise && p_addr_q[0])    h2p_pop[p_addr_q[2:1]]  = 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_reg
    localparam int unsigned D  = (g == R3) ? R3_DEPTH : 1;
    localparam int unsigned CW = $clog2(D + 1);
    logic [CW-1:0] thresh;
    // R3 drops to single-entry behaviour while V is clear.
    assign thresh = (g == R3 && !flags_q[FLAG_V]) ? CW'(1) : CW'(D);

    tube_fifo #(.DEPTH(D), .JUNK_ON_FLUSH(1'b0)) u_h2p (
      .clk(h_phi2), .rst_b(h_rst_b), .flush(flags_q[FLAG_T]),
      .push(h2p_push[g]), .pop(h2p_pop[g]), .din(h_data),
      .full_thresh(thresh), .dout(h2p_dout[g]),
      .not_empty(h2p_ne[g]), .full(h2p_full[g])
    );

    tube_fifo #(.DEPTH(D), .JUNK_ON_FLUSH(g == R3)) u_p2h (
      .clk(h_phi2), .rst_b(h_rst_b), .flush(flags_q[FLAG_T]),
      .push(p2h_push[g]), .pop(p2h_pop[g]), .din(p_wdata_q),
      .full_thresh(thresh), .dout(p2h_dout[g]),
      .not_empty(p2h_ne[g]), .full(p2h_full[g])
    );
  end

  // Read-data muxes; flags appear only in the register-1 status byte.
  always_comb begin
    h_rdata = bus.h_addr[0] ? p2h_dout[h_n]
            : status_byte(p2h_ne[h_n], ~h2p_full[h_n], (h_n == 2'd0) ? flags_q[5:0] : 6'd0);
    p_rdata = bus.p_addr[0] ? h2p_dout[p_n]
            : status_byte(h2p_ne[p_n], ~p2h_full[p_n], (p_n == 2'd0) ? flags_q[5:0] : 6'd0);
  end

  assign h_data = h_rd ? h_rdata : 8'hzz;
  assign p_data = (~bus.p_cs_b & ~bus.p_rd_b) ? p_rdata : 8'hzz;

  assign bus.p_irq_b = ~((flags_q[FLAG_Q] & h2p_ne[R1]) | (flags_q[FLAG_I] & h2p_ne[R4]));
  assign bus.h_irq_b = ~(flags_q[FLAG_J] & p2h_ne[R4]);
  assign bus.p_nmi_b = ~(flags_q[FLAG_M] & (h2p_full[R3] | ~p2h_ne[R3]));
  assign bus.p_rst_b = ~flags_q[FLAG_P] & h_rst_b;

endmodule

// File: tb/tb_tube_ula.sv
module tb_tube_ula;

  logic h_phi2 = 1'b1;
  logic h_rst_b = 1'b0;
  tube_ula_if tif();
  wire  [7:0] h_data;
  wire  [7:0] p_data;
  logic [7:0] h_drv = 8'h00, p_drv = 8'h00;
  logic       h_drv_en = 1'b0, p_drv_en = 1'b0;

  assign h_data = h_drv_en ? h_drv : 8'hzz;
  assign p_data = p_drv_en ? p_drv : 8'hzz;

  tube_ula #(.R3_DEPTH(2)) dut (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .bus(tif.slave),
    .h_data(h_data), .p_data(p_data)
  );

  always #5 h_phi2 = ~h_phi2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fifo id 0..3 = H->P R1..R4, 4..7 = P->H R1..R4.
  logic [6:0] m_flags;
  logic [7:0] m_dat [8][2];
  int         m_cnt [8];
  logic [7:0] m_last [8];

  function automatic int m_cap(int f);
    return ((f % 4) == 2 && m_flags[4]) ? 2 : 1;
  endfunction

  function automatic bit m_full(int f);
    return m_cnt[f] >= m_cap(f);
  endfunction

  function automatic void m_flush();
    for (int f = 0; f < 8; f++) begin
      m_cnt[f] = 0; m_last[f] = 8'h00; m_dat[f][0] = 8'h00; m_dat[f][1] = 8'h00;
    end
    m_cnt[6] = 1;
  endfunction

  function automatic void m_push(int f, logic [7:0] d);
    if (!m_full(f)) begin
      m_dat[f][m_cnt[f]] = d;
      m_cnt[f]++;
    end
  endfunction

  function automatic logic [7:0] m_peek(int f);
    return (m_cnt[f] != 0) ? m_dat[f][0] : m_last[f];
  endfunction

  function automatic logic [7:0] m_pop(int f);
    logic [7:0] v;
    if (m_cnt[f] == 0) return m_last[f];
    v = m_dat[f][0];
    m_dat[f][0] = m_dat[f][1];
    m_cnt[f]--;
    m_last[f] = v;
    return v;
  endfunction

  function automatic logic [7:0] m_host_status(int n);
    return {m_cnt[4+n] != 0, !m_full(n), (n == 0) ? m_flags[5:0] : 6'd0};
  endfunction

  function automatic logic [7:0] m_par_status(int n);
    return {m_cnt[n] != 0, !m_full(4+n), (n == 0) ? m_flags[5:0] : 6'd0};
  endfunction

  // {h_irq_b, p_irq_b, p_nmi_b, p_rst_b}
  function automatic logic [3:0] m_outs();
    logic hi, pi, nmi, pr;
    hi  = !(m_flags[2] && m_cnt[7] != 0);
    pi  = !((m_flags[0] && m_cnt[0] != 0) || (m_flags[1] && m_cnt[3] != 0));
    nmi = !(m_flags[3] && (m_full(2) || m_cnt[6] == 0));
    pr  = !m_flags[5] && h_rst_b;
    return {hi, pi, nmi, pr};
  endfunction

  function automatic void m_reset();
    m_flags = '0;
    m_flush();
  endfunction

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge h_phi2); #1;
    tif.h_cs_b = 1'b0; tif.h_rdnw = 1'b0; tif.h_addr = a; h_drv = d; h_drv_en = 1'b1;
    @(negedge h_phi2); #1;
    tif.h_cs_b = 1'b1; tif.h_rdnw = 1'b1; h_drv_en = 1'b0;
    @(negedge h_phi2); #1;
    if (a == 3'd0) m_flags = (m_flags & ~d[6:0]) | ({7{d[7]}} & d[6:0]);
    else if (a[0]) m_push(int'(a[2:1]), d);
    if (m_flags[6]) m_flush();
  endtask

  task automatic host_read(input logic [2:0] a, output logic [7:0] v);
    @(posedge h_phi2); #1;
    tif.h_cs_b = 1'b0; tif.h_rdnw = 1'b1; tif.h_addr = a;
    #2 v = h_data;
    @(negedge h_phi2); #1;
    tif.h_cs_b = 1'b1;
    if (a[0]) void'(m_pop(4 + int'(a[2:1])));
    if (m_flags[6]) m_flush();
  endtask

  task automatic p_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge h_phi2); #1;
    tif.p_cs_b = 1'b0; tif.p_wr_b = 1'b0; tif.p_addr = a; p_drv = d; p_drv_en = 1'b1;
    repeat (3) @(negedge h_phi2);
    @(posedge h_phi2); #1;
    tif.p_cs_b = 1'b1; tif.p_wr_b = 1'b1; p_drv_en = 1'b0;
    repeat (4) @(negedge h_phi2);
    #1;
    if (a[0]) m_push(4 + int'(a[2:1]), d);
  endtask

  task automatic p_read(input logic [2:0] a, output logic [7:0] v);
    @(posedge h_phi2); #1;
    tif.p_cs_b = 1'b0; tif.p_rd_b = 1'b0; tif.p_addr = a;
    #2 v = p_data;
    repeat (3) @(negedge h_phi2);
    @(posedge h_phi2); #1;
    tif.p_cs_b = 1'b1; tif.p_rd_b = 1'b1;
    repeat (4) @(negedge h_phi2);
    #1;
    if (a[0]) void'(m_pop(int'(a[2:1])));
  endtask

  task automatic test_reset();
    logic [7:0] v;
    h_rst_b = 1'b0;
    repeat (3) @(negedge h_phi2);
    #1;
    n_tests++;
    if (tif.p_rst_b !== 1'b0) begin n_fail++; $display("FAIL rst_prst_low: got %b want 0", tif.p_rst_b); end
    @(posedge h_phi2); #1;
    h_rst_b = 1'b1;
    @(negedge h_phi2); #1;
    m_reset();
    n_tests++;
    if ({tif.h_irq_b, tif.p_irq_b, tif.p_nmi_b, tif.p_rst_b} !== 4'b1111) begin
      n_fail++; $display("FAIL rst_outs: got %b want 1111", {tif.h_irq_b, tif.p_irq_b, tif.p_nmi_b, tif.p_rst_b});
    end
    host_read(3'd0, v);
    n_tests++;
    if (v !== 8'h40) begin n_fail++; $display("FAIL rst_hstat0: got %h want 40", v); end
    host_read(3'd4, v);
    n_tests++;
    if (v !== 8'hC0) begin n_fail++; $display("FAIL rst_hstat4: got %h want c0", v); end
    p_read(3'd4, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL rst_pstat4: got %h want 00", v); end
  endtask

  task automatic test_ctrl();
    logic [7:0] v;
    host_write(3'd0, 8'h40);
    host_write(3'd0, 8'h0F);
    host_write(3'd0, 8'h10);
    host_write(3'd0, 8'h88);
    host_read(3'd0, v);
    n_tests++;
    if (v !== 8'h48) begin n_fail++; $display("FAIL ctrl_read: got %h want 48", v); end
    host_write(3'd0, 8'h48);
    host_read(3'd0, v);
    n_tests++;
    if (v !== 8'h40) begin n_fail++; $display("FAIL ctrl_clear: got %h want 40", v); end
  endtask

  task automatic test_r1();
    logic [7:0] v;
    host_write(3'd1, 8'hAA);
    host_read(3'd0, v);
    n_tests++;
    if (v[6] !== 1'b0) begin n_fail++; $display("FAIL r1_h_nf_full: got %b want 0", v[6]); end
    p_read(3'd0, v);
    n_tests++;
    if (v[7] !== 1'b1) begin n_fail++; $display("FAIL r1_p_ne: got %b want 1", v[7]); end
    p_read(3'd1, v);
    n_tests++;
    if (v !== 8'hAA) begin n_fail++; $display("FAIL r1_p_data: got %h want aa", v); end
    host_read(3'd0, v);
    n_tests++;
    if (v[6] !== 1'b1) begin n_fail++; $display("FAIL r1_h_nf_after: got %b want 1", v[6]); end
    p_read(3'd0, v);
    n_tests++;
    if (v[7] !== 1'b0) begin n_fail++; $display("FAIL r1_p_ne_after: got %b want 0", v[7]); end
  endtask

  task automatic test_r3();
    logic [7:0] v;
    host_write(3'd0, 8'h90);
    host_write(3'd5, 8'hAA);
    host_read(3'd4, v);
    n_tests++;
    if (v[6] !== 1'b1) begin n_fail++; $display("FAIL r3_nf_one: got %b want 1", v[6]); end
    host_write(3'd5, 8'hAB);
    host_read(3'd4, v);
    n_tests++;
    if (v[6] !== 1'b0) begin n_fail++; $display("FAIL r3_nf_two: got %b want 0", v[6]); end
    host_write(3'd0, 8'h88);
    n_tests++;
    if (tif.p_nmi_b !== 1'b0) begin n_fail++; $display("FAIL r3_nmi_full: got %b want 0", tif.p_nmi_b); end
    p_read(3'd5, v);
    n_tests++;
    if (v !== 8'hAA) begin n_fail++; $display("FAIL r3_first: got %h want aa", v); end
    n_tests++;
    if (tif.p_nmi_b !== m_outs()[1]) begin n_fail++; $display("FAIL r3_nmi_after: got %b want %b", tif.p_nmi_b, m_outs()[1]); end
    p_read(3'd5, v);
    n_tests++;
    if (v !== 8'hAB) begin n_fail++; $display("FAIL r3_second: got %h want ab", v); end
    host_write(3'd0, 8'h08);
  endtask

  task automatic test_r4();
    logic [7:0] v;
    host_write(3'd0, 8'h84);
    p_write(3'd7, 8'hAA);
    n_tests++;
    if (tif.h_irq_b !== 1'b0) begin n_fail++; $display("FAIL r4_hirq_low: got %b want 0", tif.h_irq_b); end
    host_read(3'd6, v);
    n_tests++;
    if (v[7] !== 1'b1) begin n_fail++; $display("FAIL r4_h_ne: got %b want 1", v[7]); end
    host_read(3'd7, v);
    n_tests++;
    if (v !== 8'hAA) begin n_fail++; $display("FAIL r4_data: got %h want aa", v); end
    n_tests++;
    if (tif.h_irq_b !== 1'b1) begin n_fail++; $display("FAIL r4_hirq_high: got %b want 1", tif.h_irq_b); end
    host_write(3'd0, 8'h04);
  endtask

  task automatic test_junk();
    logic [7:0] v;
    host_write(3'd0, 8'h10);
    host_write(3'd0, 8'hC0);
    host_write(3'd0, 8'h40);
    p_read(3'd4, v);
    n_tests++;
    if (v[7:6] !== 2'b00) begin n_fail++; $display("FAIL junk_pstat: got %b want 00", v[7:6]); end
    host_read(3'd5, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL junk_byte: got %h want 00", v); end
    p_read(3'd4, v);
    n_tests++;
    if (v[6] !== 1'b1) begin n_fail++; $display("FAIL junk_nf: got %b want 1", v[6]); end
  endtask

  task automatic test_pflag();
    host_write(3'd0, 8'hA0);
    n_tests++;
    if (tif.p_rst_b !== 1'b0) begin n_fail++; $display("FAIL pflag_set: got %b want 0", tif.p_rst_b); end
    host_write(3'd0, 8'h20);
    n_tests++;
    if (tif.p_rst_b !== 1'b1) begin n_fail++; $display("FAIL pflag_clr: got %b want 1", tif.p_rst_b); end
    @(posedge h_phi2); #1;
    h_rst_b = 1'b0;
    #2;
    n_tests++;
    if (tif.p_rst_b !== 1'b0) begin n_fail++; $display("FAIL pflag_hrst: got %b want 0", tif.p_rst_b); end
    repeat (2) @(negedge h_phi2);
    @(posedge h_phi2); #1;
    h_rst_b = 1'b1;
    @(negedge h_phi2); #1;
    m_reset();
  endtask

  task automatic test_random();
    logic [7:0] v, exp, d;
    logic [2:0] a;
    int op, n;
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 4));
      n  = int'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      a  = 3'($urandom_range(0, 7));
      case (op)
        0: host_write({2'(n), 1'b1}, d);
        1: p_write({2'(n), 1'b1}, d);
        2: begin
          exp = a[0] ? m_peek(4 + int'(a[2:1])) : m_host_status(int'(a[2:1]));
          host_read(a, v);
          n_tests++;
          if (v !== exp) begin n_fail++; $display("FAIL rnd_host_read it=%0d addr=%0d: got %h want %h", it, a, v, exp); end
        end
        3: begin
          exp = a[0] ? m_peek(int'(a[2:1])) : m_par_status(int'(a[2:1]));
          p_read(a, v);
          n_tests++;
          if (v !== exp) begin n_fail++; $display("FAIL rnd_par_read it=%0d addr=%0d: got %h want %h", it, a, v, exp); end
        end
        default: host_write(3'd0, d & 8'hBF);
      endcase
      n_tests++;
      if ({tif.h_irq_b, tif.p_irq_b, tif.p_nmi_b, tif.p_rst_b} !== m_outs()) begin
        n_fail++;
        $display("FAIL rnd_outs it=%0d: got %b want %b", it,
                 {tif.h_irq_b, tif.p_irq_b, tif.p_nmi_b, tif.p_rst_b}, m_outs());
      end
    end
  endtask

  initial begin
    tif.h_cs_b = 1'b1; tif.h_rdnw = 1'b1; tif.h_addr = 3'd0;
    tif.p_cs_b = 1'b1; tif.p_rd_b = 1'b1; tif.p_wr_b = 1'b1; tif.p_addr = 3'd0;
    m_reset();
    test_reset();
    test_ctrl();
    test_r1();
    test_r3();
    test_r4();
    test_junk();
    test_pflag();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
